// File: rtl/regfile_pkg.sv
// Shared types and default sizing for the parameterised register file
// and its clear-sweep controller.
package regfile_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    localparam int DEF_DATA_W = 24;
    localparam int DEF_ADDR_W = 4;

endpackage

// File: rtl/regfile_clear_fsm.sv
// Sequential clear-sweep controller: walks an index across every register
// once, and reports busy, completion and writes dropped during the sweep.
module regfile_clear_fsm
    import regfile_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              Clock,
    input  logic              Reset_n,
    input  logic              ClearReq,
    input  logic              Regwrite,
    output logic              Busy,
    output logic              ClearDone,
    output logic              WriteDropped,
    output logic              sweep_en,
    output logic [ADDR_W-1:0] sweep_idx
);

    state_t            state;
    logic [ADDR_W-1:0] idx;

    // ClearReq is only honoured from IDLE, so a request mid-sweep cannot restart it.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state        <= IDLE;
            idx          <= '0;
            Busy         <= 1'b0;
            ClearDone    <= 1'b0;
            WriteDropped <= 1'b0;
        end else begin
            ClearDone    <= 1'b0;
            WriteDropped <= 1'b0;
            case (state)
                IDLE: begin
                    if (ClearReq) begin
                        state <= CLEAR;
                        idx   <= '0;
                        Busy  <= 1'b1;
                    end
                end
                CLEAR: begin
                    WriteDropped <= Regwrite;
                    if (idx == '1) begin
                        state     <= IDLE;
                        idx       <= '0;
                        Busy      <= 1'b0;
                        ClearDone <= 1'b1;
                    end else begin
                        idx <= idx + ADDR_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign sweep_en  = (state == CLEAR);
    assign sweep_idx = idx;

endmodule

// File: rtl/register_file_param.sv
// Two-read, one-write register file with write-through bypass, optional
// hardwired zero register and a sequential clear sweep.
module register_file_param
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int ZERO_REG = 1
) (
    input  logic              Clock,
    input  logic              Reset_n,
    input  logic [ADDR_W-1:0] RS,
    input  logic [ADDR_W-1:0] RT,
    input  logic [ADDR_W-1:0] RD,
    input  logic [DATA_W-1:0] WriteData,
    input  logic              Regwrite,
    input  logic              ClearReq,
    output logic [DATA_W-1:0] ReadRS,
    output logic [DATA_W-1:0] ReadRT,
    output logic              Busy,
    output logic              ClearDone,
    output logic              WriteDropped
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic              sweep_en;
    logic [ADDR_W-1:0] sweep_idx;
    logic              wr_ok;

    regfile_clear_fsm #(
        .ADDR_W (ADDR_W)
    ) u_clear_fsm (
        .Clock        (Clock),
        .Reset_n      (Reset_n),
        .ClearReq     (ClearReq),
        .Regwrite     (Regwrite),
        .Busy         (Busy),
        .ClearDone    (ClearDone),
        .WriteDropped (WriteDropped),
        .sweep_en     (sweep_en),
        .sweep_idx    (sweep_idx)
    );

    // One qualified write enable drives both storage and bypass, so they never disagree.
    assign wr_ok = Regwrite && !sweep_en && !((ZERO_REG != 0) && (RD == '0));

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (sweep_en) begin
            regs[sweep_idx] <= '0;
        end else if (wr_ok) begin
            regs[RD] <= WriteData;
        end
    end

    always_comb begin
        ReadRS = regs[RS];
        ReadRT = regs[RT];
        if (wr_ok && (RS == RD)) begin
            ReadRS = WriteData;
        end
        if (wr_ok && (RT == RD)) begin
            ReadRT = WriteData;
        end
        if ((ZERO_REG != 0) && (RS == '0)) begin
            ReadRS = '0;
        end
        if ((ZERO_REG != 0) && (RT == '0)) begin
            ReadRT = '0;
        end
    end

endmodule

// File: doc/register_file_param.md
REGISTER_FILE_PARAM -- requirements
Module: register_file_param

Interface
REQ-001 Parameter DATA_W, default 24: register width in bits.
REQ-002 Parameter ADDR_W, default 4: address width; DEPTH = 2**ADDR_W registers.
REQ-003 Parameter ZERO_REG, default 1: when 1, register 0 always reads 0 and ignores writes.
REQ-004 Clock  input  1  single clock; all state updates on rising edge.
REQ-005 Reset_n  input  1  reset, asynchronous, active-low.
REQ-006 RS  input  ADDR_W  read address, port A.
REQ-007 RT  input  ADDR_W  read address, port B.
REQ-008 RD  input  ADDR_W  write address.
REQ-009 WriteData  input  DATA_W  write data.
REQ-010 Regwrite  input  1  write enable.
REQ-011 ClearReq  input  1  single-cycle request to start a sequential clear sweep.
REQ-012 ReadRS  output  DATA_W  data read at RS, combinational.
REQ-013 ReadRT  output  DATA_W  data read at RT, combinational.
REQ-014 Busy  output  1  high while the clear sweep runs.
REQ-015 ClearDone  output  1  one-cycle pulse when the sweep completes.
REQ-016 WriteDropped  output  1  registered one-cycle pulse: a Regwrite was ignored because Busy was high.

Function
REQ-017 FSM states: IDLE, CLEAR; reset state IDLE.
REQ-018 IDLE with Regwrite=1: Registers[RD] <= WriteData at the next edge, except RD=0 when ZERO_REG=1.
REQ-019 Write-through bypass in IDLE: if Regwrite=1 and RS==RD, ReadRS = WriteData in the same cycle; same rule for RT/ReadRT; no bypass for RD=0 when ZERO_REG=1.
REQ-020 Without bypass, ReadRS/ReadRT return the stored value; a write is visible through storage from the cycle after its edge.
REQ-021 IDLE with ClearReq=1: go to CLEAR at the next edge; sweep index = 0; Busy=1 from that edge.
REQ-022 IDLE with ClearReq=1 and Regwrite=1 in the same cycle: the write is performed and is then overwritten by the sweep.
REQ-023 CLEAR: each cycle write 0 to Registers[index] and increment index; exactly DEPTH cycles, index 0 to DEPTH-1, no wrap.
REQ-024 On the edge that clears index DEPTH-1: go to IDLE, Busy=0, ClearDone=1 for exactly the following cycle.
REQ-025 CLEAR: Regwrite is ignored and produces WriteDropped=1 in the next cycle; bypass is disabled; reads return current stored values, whether cleared or not yet cleared.
REQ-026 ClearReq while Busy=1 is ignored; the sweep does not restart.
REQ-027 ZERO_REG=1: ReadRS or ReadRT is 0 whenever its address is 0, in every state.

Reset
REQ-028 Reset_n=0 asynchronously forces all registers to 0, FSM to IDLE, index to 0, and Busy, ClearDone and WriteDropped to 0.
REQ-029 Reset asserted mid-sweep aborts the sweep immediately; after release the block is in IDLE with all registers 0 and ClearDone is not pulsed.
REQ-030 First write is accepted on the first rising edge after Reset_n deasserts.

Structure
REQ-031 Shared package regfile_pkg holds the FSM state type (IDLE, CLEAR) and the default DATA_W/ADDR_W constants.
REQ-032 Sweep FSM, index counter, Busy, ClearDone and WriteDropped sit in sub-module regfile_clear_fsm; storage, bypass and read muxes stay in register_file_param.

Verification
REQ-033 Reset, write RD=5 with 0xABCDEF, read RS=5 next cycle -> ReadRS=0xABCDEF; RT=0 -> ReadRT=0.
REQ-034 Regwrite=1, RD=3, WriteData=0x123456, RS=RT=3 in the same cycle -> ReadRS=ReadRT=0x123456 in that cycle.
REQ-035 ZERO_REG=1: write RD=0 with 0xFFFFFF, Regwrite=1, RS=0 -> ReadRS=0 in the same and the next cycle.
REQ-036 Fill regs 1-15 with nonzero values, pulse ClearReq -> Busy high for 16 cycles, ClearDone one pulse, all reads 0 afterward; Regwrite during Busy -> WriteDropped pulse, register stays 0.
REQ-037 Start sweep, assert Reset_n=0 at index 7 -> Busy=0 immediately, all regs 0, FSM IDLE, no ClearDone pulse.
REQ-038 ClearReq again at index 4 -> no restart; total Busy length stays 16 cycles.
